axi_wr_slave: RTL
=================

AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, giving the word-address width of the backing memory (2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter MAX_BEATS, default 4, giving the maximum number of beats per write burst.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port awvalid, input, 1 bit: the write-address valid.
REQ-006 SHALL have port awready, output, 1 bit: the write-address ready.
REQ-007 SHALL have port awid, input, 4 bits: the transaction id.
REQ-008 SHALL have port awaddr, input, 32 bits: the byte address of the first beat.
REQ-009 SHALL have port awatop, input, 6 bits: the atomic-op code; 0 means a normal write.
REQ-010 SHALL have port wvalid, input, 1 bit: the write-data valid.
REQ-011 SHALL have port wready, output, 1 bit: the write-data ready.
REQ-012 SHALL have port wdata, input, 32 bits: the beat data.
REQ-013 SHALL have port wstrb, input, 4 bits: the byte enables, where bit n covers wdata[8n+7:8n].
REQ-014 SHALL have port wlast, input, 1 bit: marks the final beat.
REQ-015 SHALL have port bvalid, output, 1 bit: the response valid.
REQ-016 SHALL have port bready, input, 1 bit: the response ready.
REQ-017 SHALL have port bid, output, 4 bits: the echoed awid.
REQ-018 SHALL have port bcomp, output, 1 bit: 1 = write committed, 0 = write rejected.
REQ-019 SHALL have port dbg_radr, input, MEM_AW bits: the debug read word address.
REQ-020 SHALL have port dbg_rdata, output, 32 bits: the debug read data, one cycle after dbg_radr.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, DATA and RESP.
REQ-022 IDLE SHALL drive awready=1 and wready=0; on awvalid&awready SHALL capture awid, awaddr[MEM_AW+1:2] as the beat pointer and awatop, then go to DATA.
REQ-023 DATA SHALL drive awready=0 and wready=1; each wvalid&wready SHALL count as one beat.
REQ-024 On each beat, when the captured awatop==0 and the beat is not in error, SHALL write the enabled bytes of wdata to mem[ptr] with byte granularity; disabled bytes SHALL be left unchanged.
REQ-025 After each beat, ptr SHALL increment by 1 modulo 2^MEM_AW, so the address wraps at the top of memory with no error.
REQ-026 A 3-bit beat counter SHALL count beats; a beat with wlast=1 SHALL move the FSM to RESP.
REQ-027 Overrun: if the beat counter reaches MAX_BEATS with wlast=0, SHALL set a sticky err flag, discard further beats (no memory write) and stay in DATA until wlast.
REQ-028 The captured awatop!=0 (atomics unsupported) SHALL consume all beats without writing memory and set err.
REQ-029 RESP SHALL drive bvalid=1, bid=captured awid and bcomp=~err; on bvalid&bready SHALL return to IDLE, clear err and the beat counter.
REQ-030 bvalid, bid and bcomp SHALL stay stable while bvalid=1 and bready=0.
REQ-031 Latency: awready SHALL be 1 again the cycle after the bready handshake; the minimum turnaround for a 1-beat burst is 3 cycles (AW, W, B).
REQ-032 W beats arriving while in IDLE SHALL not be accepted (wready=0); AW SHALL be accepted only in IDLE, giving a single outstanding transaction.
REQ-033 The debug read port SHALL be a synchronous read of mem[dbg_radr]; on a same-address write in the same cycle, SHALL return the old data.
REQ-034 awready, wready and bvalid SHALL be registered outputs decoded from the state register.

Reset
REQ-035 While rst_n=0, SHALL force the FSM to IDLE, awready=1, wready=0, bvalid=0, bid=0, bcomp=0, err=0, beat counter=0 and ptr=0.
REQ-036 Reset asserted mid-burst or mid-response SHALL abandon the transaction with no response; memory SHALL keep the beats already written.
REQ-037 Memory contents SHALL not be reset; dbg_rdata SHALL be 0 after reset until the first read.

Structure
REQ-038 The AXI id width (4), atop width (6) and FSM state encodings SHALL be shared constants in a common package, reused by write_channels_mngr.
REQ-039 The byte-enable memory SHALL be one sub-module, bytewen_ram (simple dual-port: one write port, one read port, 4 byte-write enables), inferable as block RAM.

Verification
REQ-040 Four-beat burst, awaddr=0x100, wstrb=0xF, data 0x11111111..0x44444444, wlast on beat 4 -> bvalid with bcomp=1; dbg_radr 0x40..0x43 returns the four words.
REQ-041 A single beat with wstrb=0x5 and wdata=0xAABBCCDD over existing 0x00000000 -> mem reads 0x00BB00DD.
REQ-042 awatop=0x20 with 4 beats -> bcomp=0 and memory unchanged; the next normal write gives bcomp=1.
REQ-043 Five beats with wlast only on beat 5 -> beats 1-4 written, beat 5 discarded, bcomp=0.
REQ-044 Holding bready=0 for 5 cycles -> bvalid, bid (e.g. 0xA) and bcomp stay stable and awready=0; when bready rises, awready=1 on the next cycle.
REQ-045 rst_n pulsed low after beat 2 of 4 -> outputs take their reset values immediately with no bvalid; the two words already written remain readable.

Source files
------------

// File: rtl/axi_wr_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_slave_pkg
// Shared constants and types for the AXI write slave: AXI id / atop widths,
// data and strobe widths, and the write-channel FSM state encoding.
// No ports; imported by write_channels_mngr, bytewen_ram and axi_wr_slave.
// ---------------------------------------------------------------------------
package axi_wr_slave_pkg;

  localparam int ID_W   = 4;
  localparam int ATOP_W = 6;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

  // Any non-zero atop code is an atomic operation, which this slave rejects.
  function automatic logic is_atomic(input logic [ATOP_W-1:0] atop);
    return (atop != {ATOP_W{1'b0}});
  endfunction

endpackage

// File: rtl/bytewen_ram.sv
// ---------------------------------------------------------------------------
// bytewen_ram
// Simple dual-port RAM, 2^AW words of DATA_W bits, with per-byte write
// enables. Read is synchronous and returns the old word on a same-address
// write in the same cycle. The array itself is never reset; only the read
// data register is cleared by reset.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (read register only)
//   we, waddr,
//   wdata, wbe      write port; wbe[n] enables wdata[8n+7:8n]
//   raddr, rdata    read port; rdata valid one cycle after raddr
// ---------------------------------------------------------------------------
module bytewen_ram
  import axi_wr_slave_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wbe,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Byte-granular write port; disabled bytes keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; non-blocking semantics give read-old-data on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DATA_W{1'b0}};
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/write_channels_mngr.sv
// ---------------------------------------------------------------------------
// write_channels_mngr
// AW/W/B channel controller: IDLE accepts one address, DATA consumes beats
// and issues byte-enabled memory writes, RESP holds the write response until
// it is taken. Atomic requests and bursts longer than MAX_BEATS are answered
// with bcomp=0; extra beats and all atomic beats never reach memory.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   awvalid/awready/awid/
//   awaddr/awatop                   write address channel
//   wvalid/wready/wdata/wstrb/wlast write data channel
//   bvalid/bready/bid/bcomp         write response channel
//   mem_we/mem_waddr/
//   mem_wdata/mem_wbe               write port towards bytewen_ram
// ---------------------------------------------------------------------------
module write_channels_mngr
  import axi_wr_slave_pkg::*;
#(
  parameter int MEM_AW    = 12,
  parameter int MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [ATOP_W-1:0] awatop,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic              bcomp,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wbe
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_BEATS);

  wr_state_e           state;
  logic [ID_W-1:0]     id_q;
  logic [ATOP_W-1:0]   atop_q;
  logic [MEM_AW-1:0]   ptr;
  logic [2:0]          beat_cnt;
  logic                err;

  logic                beat;
  logic                beat_ovr;
  logic                beat_sets_err;
  logic                err_next;

  // Only the word-address bits of awaddr select memory; the rest are ignored.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[31:MEM_AW+2], awaddr[1:0]};

  // Beat qualification and the memory write request for the current beat.
  // A burst that has used MAX_BEATS beats without wlast is an overrun: the
  // MAX_BEATS-th beat is still written but flags the error, later beats are
  // dropped.
  always_comb begin
    beat          = wvalid & wready;
    beat_ovr      = (beat_cnt >= MAX_CNT);
    beat_sets_err = beat & (beat_ovr | ((beat_cnt == (MAX_CNT - 3'd1)) & ~wlast));
    err_next      = err | beat_sets_err;
    mem_we        = beat & ~is_atomic(atop_q) & ~beat_ovr;
    mem_waddr     = ptr;
    mem_wdata     = wdata;
    mem_wbe       = wstrb;
  end

  // Write-channel FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= {ID_W{1'b0}};
      bcomp    <= 1'b0;
      id_q     <= {ID_W{1'b0}};
      atop_q   <= {ATOP_W{1'b0}};
      ptr      <= {MEM_AW{1'b0}};
      beat_cnt <= 3'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (awvalid && awready) begin
            id_q     <= awid;
            atop_q   <= awatop;
            ptr      <= awaddr[MEM_AW+1:2];
            beat_cnt <= 3'd0;
            err      <= is_atomic(awatop);
            awready  <= 1'b0;
            wready   <= 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            // Pointer advances on every beat, dropped or not, and wraps.
            ptr <= ptr + MEM_AW'(1);
            err <= err_next;
            if (!beat_ovr) begin
              beat_cnt <= beat_cnt + 3'd1;
            end
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bcomp  <= ~err_next;
              state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bvalid && bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            err      <= 1'b0;
            beat_cnt <= 3'd0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_slave.sv
// ---------------------------------------------------------------------------
// axi_wr_slave
// Single-outstanding AXI-style write slave backed by a 2^MEM_AW x 32-bit
// byte-enable memory, with a debug read port for inspecting the memory.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   awvalid/awready/awid/
//   awaddr/awatop                   write address channel (awatop!=0 rejected)
//   wvalid/wready/wdata/wstrb/wlast write data channel
//   bvalid/bready/bid/bcomp         write response (bcomp=1 committed)
//   dbg_radr/dbg_rdata              synchronous debug read, 1-cycle latency
// ---------------------------------------------------------------------------
module axi_wr_slave
  import axi_wr_slave_pkg::*;
#(
  parameter int MEM_AW    = 12,
  parameter int MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [ATOP_W-1:0] awatop,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic              bcomp,
  input  logic [MEM_AW-1:0] dbg_radr,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wbe;

  write_channels_mngr #(
    .MEM_AW    (MEM_AW),
    .MAX_BEATS (MAX_BEATS)
  ) u_mngr (
    .clk       (clk),
    .rst_n     (rst_n),
    .awvalid   (awvalid),
    .awready   (awready),
    .awid      (awid),
    .awaddr    (awaddr),
    .awatop    (awatop),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bcomp     (bcomp),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wbe   (mem_wbe)
  );

  bytewen_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wbe   (mem_wbe),
    .raddr (dbg_radr),
    .rdata (dbg_rdata)
  );

endmodule
